// File: rtl/rmw_mem_responder.sv
// Memory-side responder for a read-modify-write handshake: reads a word, hands it to an
// external modify engine, writes the returned word back, and aborts via watchdog on silence.
module rmw_mem_responder #(
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  input  logic [AW-1:0] req_addr_i,
  output logic          req_ready_o,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  input  logic          wr_valid_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          done_o,
  output logic          err_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [DW-1:0] dbg_data_o
);

  localparam int unsigned Depth = 1 << AW;
  localparam int unsigned CntW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWaitMod, StWrite} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic [DW-1:0]   wr_q, wr_d;
  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;
  logic [DW-1:0]   mem_q [Depth];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_data_d = rd_data_q;
    wr_d      = wr_q;
    wd_cnt_d  = wd_cnt_q;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          state_d = StRead;
        end
      end
      StRead: begin
        rd_data_d = mem_q[addr_q];
        wd_cnt_d  = '0;
        state_d   = StWaitMod;
      end
      StWaitMod: begin
        // A strobe arriving on the final watchdog cycle still completes normally.
        if (wr_valid_i) begin
          wr_d    = wr_data_i;
          state_d = StWrite;
        end else if (wd_cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rd_data_q <= '0;
      wr_q      <= '0;
      wd_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_data_q <= rd_data_d;
      wr_q      <= wr_d;
      wd_cnt_q  <= wd_cnt_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == StWrite) begin
      mem_q[addr_q] <= wr_q;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rd_valid_o  = (state_q == StWaitMod);
  assign done_o      = (state_q == StWrite);
  assign err_o       = err_q;
  assign rd_data_o   = rd_data_q;
  assign dbg_data_o  = mem_q[dbg_addr_i];

endmodule
